// File: rtl/conv_psum_requant_pack_if.sv
// Stream bundle for the psum requantizer: psum beats in (s_*), packed int8 words out (m_*).
// The master view belongs to the producer/consumer pair; the requant block uses the slave view.
interface conv_psum_requant_pack_if #(
    parameter int PSUM_W = 16,
    parameter int OUT_W  = 8,
    parameter int PACK   = 4
);
    logic                    s_valid;
    logic                    s_ready;
    logic [PSUM_W-1:0]       s_psum;
    logic                    s_last;
    logic                    m_valid;
    logic                    m_ready;
    logic [PACK*OUT_W-1:0]   m_data;
    logic [PACK-1:0]         m_keep;
    logic                    m_last;

    modport master (
        output s_valid, s_psum, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_keep, m_last
    );

    modport slave (
        input  s_valid, s_psum, s_last, m_ready,
        output s_ready, m_valid, m_data, m_keep, m_last
    );
endinterface

// File: rtl/conv_psum_requant_pack.sv
// Psum drain: bias add, rounding shift, int8 saturation and 4-lane packing with global stall.
// Optional ReLU on the requantized lanes is enabled by defining REQUANT_RELU_EN.
module conv_psum_requant_pack #(
    parameter int PSUM_W  = 16,
    parameter int OUT_W   = 8,
    parameter int PACK    = 4,
    parameter int SHIFT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic [PSUM_W-1:0]    cfg_bias,
`ifdef REQUANT_RELU_EN
    input  logic                 cfg_relu,
`endif
    input  logic                 clr_sat,
    output logic [15:0]          sat_cnt,
    conv_psum_requant_pack_if.slave bus
);
    localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic signed [PSUM_W+1:0] SAT_MAX = (PSUM_W+2)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [PSUM_W+1:0] SAT_MIN = -SAT_MAX - 1;

    logic                     en;
    logic                     s1_valid;
    logic signed [PSUM_W:0]   s1_sum;
    logic [SHIFT_W-1:0]       s1_shift;
    logic                     s1_last;

    logic signed [PSUM_W+1:0] sum_ext;
    logic signed [PSUM_W+1:0] rnd;
    logic signed [PSUM_W+1:0] r;
    logic [OUT_W-1:0]         lane;
    logic                     lane_sat;

    logic [IDX_W-1:0]         idx;
    logic [PACK*OUT_W-1:0]    stage_data;
    logic [PACK-1:0]          stage_keep;
    logic [PACK*OUT_W-1:0]    next_data;
    logic [PACK-1:0]          next_keep;
    logic                     word_done;

    logic                     m_valid_q;
    logic [PACK*OUT_W-1:0]    m_data_q;
    logic [PACK-1:0]          m_keep_q;
    logic                     m_last_q;

    assign en          = !m_valid_q || bus.m_ready;
    assign bus.s_ready = en;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_keep  = m_keep_q;
    assign bus.m_last  = m_last_q;

    // Bias add is done one bit wider so the sum can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_shift <= '0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.s_valid;
            if (bus.s_valid) begin
                s1_sum   <= $signed({bus.s_psum[PSUM_W-1], bus.s_psum})
                          + $signed({cfg_bias[PSUM_W-1], cfg_bias});
                s1_shift <= cfg_shift;
                s1_last  <= bus.s_last;
            end
        end
    end

    // Rounding constant is 2^(shift-1), which collapses to 0 when shift is 0.
    always_comb begin
        sum_ext  = {s1_sum[PSUM_W], s1_sum};
        rnd      = ((PSUM_W+2)'(1) << s1_shift) >> 1;
        r        = (sum_ext + rnd) >>> s1_shift;
        lane     = r[OUT_W-1:0];
        lane_sat = 1'b0;
        if (r > SAT_MAX) begin
            lane     = SAT_MAX[OUT_W-1:0];
            lane_sat = 1'b1;
        end else if (r < SAT_MIN) begin
            lane     = SAT_MIN[OUT_W-1:0];
            lane_sat = 1'b1;
        end
`ifdef REQUANT_RELU_EN
        if (cfg_relu && lane[OUT_W-1]) begin
            lane     = '0;
            lane_sat = 1'b0;
        end
`endif
    end

    always_comb begin
        next_data                         = stage_data;
        next_data[idx*OUT_W +: OUT_W]     = lane;
        next_keep                         = stage_keep;
        next_keep[idx]                    = 1'b1;
        word_done                         = s1_last || (idx == IDX_W'(PACK-1));
    end

    // The output register only changes while the stall is open, so m_* stay put under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            stage_data <= '0;
            stage_keep <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
        end else if (en) begin
            if (s1_valid && word_done) begin
                m_valid_q  <= 1'b1;
                m_data_q   <= next_data;
                m_keep_q   <= next_keep;
                m_last_q   <= s1_last;
                idx        <= '0;
                stage_data <= '0;
                stage_keep <= '0;
            end else begin
                m_valid_q <= 1'b0;
                if (s1_valid) begin
                    stage_data <= next_data;
                    stage_keep <= next_keep;
                    idx        <= idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (clr_sat) begin
            sat_cnt <= '0;
        end else if (en && s1_valid && lane_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_conv_psum_requant_pack.sv
// Directed bench for conv_psum_requant_pack: packing, rounding, saturation, flush,
// backpressure, throughput and asynchronous reset mid-tile.
module tb_conv_psum_requant_pack;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cfg_shift;
    logic [15:0] cfg_bias;
    logic        clr_sat;
    logic [15:0] sat_cnt;
`ifdef REQUANT_RELU_EN
    logic        cfg_relu = 1'b0;
`endif

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleCount    = 0;

    logic [31:0] wordData[$];
    logic [3:0]  wordKeep[$];
    logic        wordLast[$];
    int          wordCycle[$];

    conv_psum_requant_pack_if #(.PSUM_W(16), .OUT_W(8), .PACK(4)) bus();

    conv_psum_requant_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_shift (cfg_shift),
        .cfg_bias  (cfg_bias),
`ifdef REQUANT_RELU_EN
        .cfg_relu  (cfg_relu),
`endif
        .clr_sat   (clr_sat),
        .sat_cnt   (sat_cnt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // m_ready only moves just after a rising edge, so the negedge view is what the next edge accepts.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            wordData.push_back(bus.m_data);
            wordKeep.push_back(bus.m_keep);
            wordLast.push_back(bus.m_last);
            wordCycle.push_back(cycleCount);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] psum, input logic last);
        int   waited = 0;
        logic readySample;
        bus.s_valid = 1'b1;
        bus.s_psum  = psum;
        bus.s_last  = last;
        forever begin
            @(negedge clk);
            readySample = bus.s_ready;
            @(posedge clk);
            #1;
            if (readySample) break;
            waited++;
            if (waited > 200) begin
                checkOutput("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idleBus();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_psum  = '0;
    endtask

    task automatic clearWords();
        wordData.delete();
        wordKeep.delete();
        wordLast.delete();
        wordCycle.delete();
    endtask

    task automatic expectWord(input string tag, input logic [31:0] data, input logic [3:0] keep, input logic last);
        int waited = 0;
        while (wordData.size() == 0 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (wordData.size() == 0) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            checkOutput({tag, "_data"}, wordData.pop_front(), data);
            checkOutput({tag, "_keep"}, 32'(wordKeep.pop_front()), 32'(keep));
            checkOutput({tag, "_last"}, 32'(wordLast.pop_front()), 32'(last));
            void'(wordCycle.pop_front());
        end
    endtask

    initial begin
        int waited;
        bus.s_valid = 1'b0;
        bus.s_psum  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        cfg_shift   = 4'd0;
        cfg_bias    = 16'd0;
        clr_sat     = 1'b0;

        #12;
        checkOutput("reset_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("reset_s_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("reset_m_data",  bus.m_data,       32'd0);
        checkOutput("reset_m_keep",  32'(bus.m_keep),  32'd0);
        checkOutput("reset_sat_cnt", 32'(sat_cnt),     32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic packing and word completion without last.
        applyStimulus(16'd1, 1'b0);
        applyStimulus(16'd2, 1'b0);
        applyStimulus(16'd3, 1'b0);
        applyStimulus(16'd4, 1'b1);
        idleBus();
        expectWord("basic", 32'h04030201, 4'hF, 1'b1);
        checkOutput("basic_sat", 32'(sat_cnt), 32'd0);

        applyStimulus(16'h0011, 1'b0);
        applyStimulus(16'h0022, 1'b0);
        applyStimulus(16'h0033, 1'b0);
        applyStimulus(16'h0044, 1'b0);
        idleBus();
        expectWord("full_nolast", 32'h44332211, 4'hF, 1'b0);

        // Rounding: 24->2, -24->-1, 8->1, 7->0 with shift 4.
        cfg_shift = 4'd4;
        applyStimulus(16'd24,   1'b0);
        applyStimulus(16'hFFE8, 1'b0);
        applyStimulus(16'd8,    1'b0);
        applyStimulus(16'd7,    1'b1);
        idleBus();
        expectWord("round", 32'h0001FF02, 4'hF, 1'b1);
        checkOutput("round_sat", 32'(sat_cnt), 32'd0);

        // Saturation both ways, then clear.
        cfg_shift = 4'd0;
        applyStimulus(16'd300,  1'b0);
        applyStimulus(16'hFED4, 1'b1);
        idleBus();
        expectWord("sat", 32'h0000807F, 4'h3, 1'b1);
        checkOutput("sat_cnt_two", 32'(sat_cnt), 32'd2);
        clr_sat = 1'b1;
        @(posedge clk);
        #1;
        clr_sat = 1'b0;
        checkOutput("sat_cnt_clr", 32'(sat_cnt), 32'd0);

        // Bias pushes the sum past 16 bits: 65534 rounds to 256 and clamps.
        cfg_shift = 4'd8;
        cfg_bias  = 16'h7FFF;
        applyStimulus(16'h7FFF, 1'b1);
        idleBus();
        expectWord("bias_sat", 32'h0000007F, 4'h1, 1'b1);
        checkOutput("bias_sat_cnt", 32'(sat_cnt), 32'd1);
        cfg_shift = 4'd0;
        cfg_bias  = 16'd0;

        // Partial flush, then the next beat must start in lane 0.
        applyStimulus(16'd5, 1'b0);
        applyStimulus(16'd6, 1'b0);
        applyStimulus(16'd7, 1'b1);
        idleBus();
        expectWord("flush", 32'h00070605, 4'h7, 1'b1);
        applyStimulus(16'h0021, 1'b1);
        idleBus();
        expectWord("after_flush", 32'h00000021, 4'h1, 1'b1);

        // Sustained throughput: back-to-back words four cycles apart.
        clearWords();
        for (int i = 1; i <= 8; i++) applyStimulus(16'(i), (i == 8));
        idleBus();
        waited = 0;
        while (wordData.size() < 2 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (wordData.size() < 2) checkOutput("thru_timeout", 32'd0, 32'd1);
        else checkOutput("thru_spacing", 32'(wordCycle[1] - wordCycle[0]), 32'd4);
        expectWord("thru_w0", 32'h04030201, 4'hF, 1'b0);
        expectWord("thru_w1", 32'h08070605, 4'hF, 1'b1);

        // Backpressure: hold the first word while the producer keeps pushing.
        bus.m_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) applyStimulus(16'(8'h30 + i), (i == 8));
                idleBus();
            end
        join_none
        waited = 0;
        while (!bus.m_valid && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("bp_m_valid", 32'(bus.m_valid), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("bp_s_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("bp_hold_data", bus.m_data, 32'h34333231);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_stable_data", bus.m_data, 32'h34333231);
        checkOutput("bp_stable_keep", 32'(bus.m_keep), 32'hF);
        bus.m_ready = 1'b1;
        wait fork;
        expectWord("bp_w0", 32'h34333231, 4'hF, 1'b0);
        expectWord("bp_w1", 32'h38373635, 4'hF, 1'b1);

        // Asynchronous reset in the middle of a tile.
        applyStimulus(16'h0051, 1'b0);
        applyStimulus(16'h0052, 1'b0);
        idleBus();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("rst_m_data",  bus.m_data,       32'd0);
        checkOutput("rst_m_keep",  32'(bus.m_keep),  32'd0);
        checkOutput("rst_m_last",  32'(bus.m_last),  32'd0);
        checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("rst_sat_cnt", 32'(sat_cnt),     32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clearWords();
        applyStimulus(16'd9,  1'b0);
        applyStimulus(16'd10, 1'b0);
        applyStimulus(16'd11, 1'b0);
        applyStimulus(16'd12, 1'b1);
        idleBus();
        expectWord("post_rst", 32'h0C0B0A09, 4'hF, 1'b1);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
